// File: rtl/sensor_frame_packetizer.sv
// sensor_frame_packetizer
// Frames a flow-controlled 32-bit sample stream into Avalon-ST packets:
// one header beat {HEADER_MAGIC, frame_count}, PAYLOAD_WORDS sample beats and,
// when the PKT_TRAILER_EN macro is defined, one trailer beat carrying the
// 32-bit modular sum of the payload. Without PKT_TRAILER_EN the trailer state
// and checksum are removed and endofpacket rides on the last payload beat.
//
// Handshake: a source beat transfers on a clk edge where st_valid && st_ready
// (ready latency 0); a sample is consumed on an edge where smp_valid && smp_ready.
// In PAYLOAD the sample stream passes straight through with no added latency.
module sensor_frame_packetizer #(
  parameter int unsigned PAYLOAD_WORDS = 64,
  parameter logic [15:0] HEADER_MAGIC  = 16'hB1E5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [31:0] smp_data,
  input  logic        smp_valid,
  output logic        smp_ready,
  output logic [31:0] st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic [1:0]  st_empty,
  output logic        st_startofpacket,
  output logic        st_endofpacket,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  drop_count,
  output logic [1:0]  dbg_state
);

  // Sized so the counter never wraps inside a packet.
  localparam int CNT_W = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [7:0]       drop_count_q, drop_count_d;
`ifdef PKT_TRAILER_EN
  logic [31:0]      checksum_q, checksum_d;
`endif

  logic last_word;
  assign last_word = (word_cnt_q == LAST_IDX);

  // State and counter registers; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      frame_count_q <= 16'h0000;
      drop_count_q  <= 8'h00;
`ifdef PKT_TRAILER_EN
      checksum_q    <= 32'h0000_0000;
`endif
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
`ifdef PKT_TRAILER_EN
      checksum_q    <= checksum_d;
`endif
    end
  end

  // Next-state, counters and checksum; requests while busy are counted, not queued.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
`ifdef PKT_TRAILER_EN
    checksum_d    = checksum_q;
`endif

    if (frame_start && (state_q != S_IDLE) && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_HEADER;
      end
      S_HEADER: begin
        // Header is always valid, so ready alone completes the beat.
        if (st_ready) begin
          state_d    = S_PAYLOAD;
          word_cnt_d = '0;
`ifdef PKT_TRAILER_EN
          checksum_d = 32'h0000_0000;
`endif
        end
      end
      S_PAYLOAD: begin
        if (smp_valid && st_ready) begin
          word_cnt_d = word_cnt_q + 1'b1;
`ifdef PKT_TRAILER_EN
          checksum_d = checksum_q + smp_data;
          if (last_word) state_d = S_TRAILER;
`else
          if (last_word) begin
            state_d       = S_IDLE;
            frame_count_d = frame_count_q + 16'd1;
          end
`endif
        end
      end
`ifdef PKT_TRAILER_EN
      S_TRAILER: begin
        if (st_ready) begin
          state_d       = S_IDLE;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Source/sink outputs decoded from state; PAYLOAD passes the sample stream through.
  always_comb begin
    st_data          = 32'h0000_0000;
    st_valid         = 1'b0;
    st_startofpacket = 1'b0;
    st_endofpacket   = 1'b0;
    smp_ready        = 1'b0;
    case (state_q)
      S_HEADER: begin
        st_data          = {HEADER_MAGIC, frame_count_q};
        st_valid         = 1'b1;
        st_startofpacket = 1'b1;
      end
      S_PAYLOAD: begin
        st_data   = smp_data;
        st_valid  = smp_valid;
        smp_ready = st_ready;
`ifndef PKT_TRAILER_EN
        st_endofpacket = last_word && smp_valid;
`endif
      end
`ifdef PKT_TRAILER_EN
      S_TRAILER: begin
        st_data        = checksum_q;
        st_valid       = 1'b1;
        st_endofpacket = 1'b1;
      end
`endif
      default: begin
        st_data = 32'h0000_0000;
      end
    endcase
  end

  assign st_empty    = 2'b00;
  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/sensor_frame_packetizer.md
Name: sensor_frame_packetizer

Overview:
- Upstream neighbour of the 32-to-16 Avalon-ST width converter.
- Takes a flow-controlled raw 32-bit sensor sample stream and frames it into Avalon-ST packets: header word, PAYLOAD_WORDS samples, optional checksum trailer.
- Drives startofpacket/endofpacket so the downstream converter can lock onto packet boundaries.
- Includes frame and drop counters for the status registers.

Parameters:
- PAYLOAD_WORDS, 64: samples per packet; legal range 1..65535.
- HEADER_MAGIC, 16'hB1E5: upper 16 bits of the header word.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  single-cycle request to begin one packet
- smp_data  in  32  raw sample
- smp_valid  in  1  sample valid
- smp_ready  out  1  sample accepted when smp_valid and smp_ready are both high
- st_data  out  32  Avalon-ST source data
- st_valid  out  1  source valid
- st_ready  in  1  source ready; 0 ready latency
- st_empty  out  2  always 2'b00
- st_startofpacket  out  1  high on the header beat
- st_endofpacket  out  1  high on the last beat of a packet
- busy  out  1  high in any state other than IDLE
- frame_count  out  16  completed packets, wraps
- drop_count  out  8  ignored frame_start pulses, saturating

Behaviour:
- Reset (async): state=IDLE, all counters and the checksum = 0. All outputs 0: st_data, st_valid, st_startofpacket, st_endofpacket, smp_ready, busy, frame_count, drop_count.
- A reset mid-packet truncates the packet with no endofpacket; the downstream converter shares rst.
- Beat handshake: a beat transfers on a clk edge where st_valid && st_ready.
- States: IDLE, HEADER, PAYLOAD, TRAILER.
- IDLE:
  - st_valid=0, smp_ready=0.
  - frame_start=1 -> HEADER next cycle.
- HEADER:
  - st_data={HEADER_MAGIC, frame_count}, st_valid=1, st_startofpacket=1.
  - Held stable until accepted.
  - On accept: checksum cleared, word counter=0, go to PAYLOAD.
- PAYLOAD: combinational pass-through, zero latency.
  - st_data=smp_data, st_valid=smp_valid, smp_ready=st_ready.
  - On each accepted beat: checksum += smp_data (mod 2^32), word counter++.
  - Last beat is the one accepted while word counter == PAYLOAD_WORDS-1.
  - With PKT_TRAILER_EN: last beat -> TRAILER, st_endofpacket=0.
  - Without PKT_TRAILER_EN: st_endofpacket=1 on the last beat; on accept -> IDLE, frame_count++.
  - smp_valid low stalls the packet indefinitely; no timeout.
- TRAILER:
  - st_data=checksum, st_valid=1, st_endofpacket=1, smp_ready=0.
  - On accept -> IDLE, frame_count++.
- Samples offered in IDLE, HEADER or TRAILER are not accepted (smp_ready=0); upstream holds them.
- frame_start while busy=1 is ignored and drop_count++ (saturates at 8'hFF).
- This includes the cycle of the final accepted beat; no pending request is stored.
- frame_count wraps 16'hFFFF -> 0; the header always carries the pre-increment value.
- PAYLOAD_WORDS=1: header, one payload beat, then trailer if enabled; the payload beat carries eop when the trailer is disabled.
- Word counter width = clog2(PAYLOAD_WORDS+1); no wrap within a packet.
- st_startofpacket and st_endofpacket are never high on the same beat; every packet is at least 2 beats.
- All state and control outputs are registered except the PAYLOAD pass-through paths.

Optional Feature:
- Macro: PKT_TRAILER_EN.
- Defined: one trailer beat carrying the 32-bit modular sum of the payload; eop on the trailer.
  - Packet length = PAYLOAD_WORDS+2 beats.
- Undefined: TRAILER state and checksum logic removed; eop on the last payload beat.
  - Packet length = PAYLOAD_WORDS+1 beats.

Test Plan:
- Basic packet (PAYLOAD_WORDS=4, trailer on, st_ready=1): frame_start, then samples 1,2,3,4 -> beats B1E50000(sop), 1, 2, 3, 4, 0000000A(eop); frame_count=1.
- Backpressure: st_ready toggled 1/0 each cycle, samples 0x11111111..0x44444444 -> data stable while stalled, no loss or duplication; trailer=AAAAAAAA; smp_ready mirrors st_ready only in PAYLOAD.
- Dropped requests: frame_start pulsed 3 times mid-packet, including the eop-accept cycle -> drop_count=3, no extra packet; 300 drops -> drop_count=FF.
- Wrap: force 65536 packets (or preload frame_count=FFFF) -> header FFFF, then frame_count=0000, next header B1E50000.
- Reset mid-payload after 2 beats -> all outputs 0 immediately (async); next frame_start gives a clean sop header with frame_count 0.
- Trailer disabled (PAYLOAD_WORDS=1): frame_start, sample 0xDEADBEEF -> beats B1E50000(sop), DEADBEEF(eop); st_empty=0 throughout.
